dmem_ctrl: RTL and testbench

Data-memory controller that sits directly downstream of the RV32I core's MEM stage on the data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It holds a word-organised RAM, inserts a configurable number of wait states, and raises ACKD_n high while an access is pending so the core's interlock freezes the pipeline. It also handles byte-lane steering, right-aligned read data and misaligned/out-of-range error detection.

---
 rtl/dmem_ctrl_if.sv | 28 ++
 rtl/dmem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/acknowledge signals between the core's MEM stage and
// the data-memory controller.
//   DAD    - byte address (master -> slave)
//   MREQ   - access request (master -> slave)
//   WRITE  - 1 = store, 0 = load (master -> slave)
//   SIZE   - 00 byte, 01 half, 10 word, 11 illegal (master -> slave)
//   ACKD_n - 0 = access completes this cycle (slave -> master)
//   err    - error pulse during the acknowledge cycle (slave -> master)
// The bidirectional DDT bus is kept as a plain inout port on the controller so
// that its tri-state resolution stays on an ordinary net.
interface dmem_ctrl_if;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n;
    logic        err;

    modport master (
        output DAD, MREQ, WRITE, SIZE,
        input  ACKD_n, err
    );

    modport slave (
        input  DAD, MREQ, WRITE, SIZE,
        output ACKD_n, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data RAM behind the core's data bus.
// Inserts WAIT_CYCLES wait states, then acknowledges for one cycle with
// ACKD_n=0. Handles byte/half/word lane steering, right-aligned zero-extended
// reads, and flags misaligned, illegal-size and out-of-range accesses.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - dmem_ctrl_if.slave (DAD, MREQ, WRITE, SIZE, ACKD_n, err)
//   DDT   - bidirectional data bus; driven here only during the ACK of a load
module dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_ctrl_if.slave       bus,
    inout  wire  [31:0]      DDT
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic        ackd_n_q;

    logic [31:0] off;
    logic [1:0]  boff;
    logic [AW-1:0] widx;
    logic        err_c;
    logic        enter_ack;
    logic        wr_commit;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] rdata;

    // ---------------- address decode / error detection ----------------
    always_comb begin
        off   = bus.DAD - BASE_ADDR;
        boff  = bus.DAD[1:0];
        widx  = off[AW+1:2];
        err_c = (bus.DAD < BASE_ADDR)
              || ((off >> 2) >= 32'(DEPTH_WORDS))
              || (bus.SIZE == 2'b11)
              || (bus.SIZE == 2'b01 && bus.DAD[0])
              || (bus.SIZE == 2'b10 && bus.DAD[1:0] != 2'b00);
    end

    // The RAM read is registered on the edge that enters ACK; the core already
    // holds the address stable from the first request cycle onward.
    always_comb begin
        enter_ack = 1'b0;
        if (bus.MREQ) begin
            if (state_q == S_IDLE && WAIT_CYCLES == 0)
                enter_ack = 1'b1;
            else if (state_q == S_WAIT && wcnt_q == 4'd0)
                enter_ack = 1'b1;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 4'd0;
            ackd_n_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.MREQ) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q  <= S_ACK;
                            ackd_n_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT;
                            wcnt_q  <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.MREQ) begin
                        // Abort: nothing has been written yet, just drop out.
                        state_q <= S_IDLE;
                    end else if (wcnt_q == 4'd0) begin
                        state_q  <= S_ACK;
                        ackd_n_q <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    state_q  <= S_IDLE;
                    ackd_n_q <= 1'b1;
                end
                default: begin
                    state_q  <= S_IDLE;
                    ackd_n_q <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- write steering ----------------
    always_comb begin
        be    = 4'b0000;
        wdata = DDT;
        case (bus.SIZE)
            2'b00: begin
                be    = 4'b0001 << boff;
                wdata = {4{DDT[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << boff;
                wdata = {2{DDT[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wdata = DDT;
            end
            default: begin
                be    = 4'b0000;
                wdata = DDT;
            end
        endcase
    end

    // Commit happens on the edge that ends ACK; an asynchronous reset during
    // ACK forces state_q to IDLE first, which discards the write.
    assign wr_commit = (state_q == S_ACK) && bus.WRITE && !err_c;

    // ---------------- RAM: one 8-bit array per byte lane ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_commit && be[gi])
                    mem[widx] <= wdata[8*gi +: 8];
                if (enter_ack)
                    rd_q <= mem[widx];
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    // ---------------- read alignment ----------------
    always_comb begin
        rd_shift = rd_word >> {boff, 3'b000};
        rdata    = 32'h0;
        case (bus.SIZE)
            2'b00:   rdata = {24'h0, rd_shift[7:0]};
            2'b01:   rdata = {16'h0, rd_shift[15:0]};
            2'b10:   rdata = rd_word;
            default: rdata = 32'h0;
        endcase
        if (err_c)
            rdata = 32'h0;
    end

    // WRITE is checked directly so the bus is never driven during a store.
    assign DDT = (state_q == S_ACK && !bus.WRITE) ? rdata : {32{1'bz}};

    assign bus.ACKD_n = ackd_n_q;
    assign bus.err    = (state_q == S_ACK) && err_c;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed-vector bench for dmem_ctrl.
// u_dut  : BASE_ADDR=0x1000, 1024 words, 2 wait states (main function).
// u_dut0 : BASE_ADDR=0, 0 wait states (back-to-back acknowledge pattern).
module tb_dmem_ctrl;
    localparam logic [31:0] B = 32'h0000_1000;

    logic clk;
    logic rst_n;

    dmem_ctrl_if bus ();
    dmem_ctrl_if bus0 ();

    wire  [31:0] ddt;
    wire  [31:0] ddt0;
    logic [31:0] tb_wdata;
    logic        tb_drv_en;

    assign ddt = tb_drv_en ? tb_wdata : {32{1'bz}};

    dmem_ctrl #(
        .BASE_ADDR   (B),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .DDT   (ddt)
    );

    dmem_ctrl #(
        .BASE_ADDR   (32'h0),
        .DEPTH_WORDS (64),
        .WAIT_CYCLES (0)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave),
        .DDT   (ddt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // One complete access on u_dut; called and returns at a falling edge.
    task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat);
        bus.DAD   = addr;
        bus.SIZE  = sz;
        bus.WRITE = wr;
        bus.MREQ  = 1'b1;
        tb_wdata  = wd;
        tb_drv_en = wr;
        lat = 0;
        while (bus.ACKD_n && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = ddt;
        er = bus.err;
        @(posedge clk);
        #1;
        check("ack_one_cycle", {31'h0, bus.ACKD_n}, 32'h1);
        bus.MREQ  = 1'b0;
        bus.WRITE = 1'b0;
        tb_drv_en = 1'b0;
        @(negedge clk);
        $display("txn wr=%0d size=%0d addr=%08h wd=%08h rd=%08h err=%0d lat=%0d",
                 wr, sz, addr, wd, rd, er, lat);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          lows;

    initial begin
        rst_n = 1'b0;
        bus.DAD = 32'h0;  bus.MREQ = 1'b0;  bus.WRITE = 1'b0;  bus.SIZE = 2'b10;
        bus0.DAD = 32'h0; bus0.MREQ = 1'b0; bus0.WRITE = 1'b0; bus0.SIZE = 2'b10;
        tb_wdata = 32'h0;
        tb_drv_en = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_ackd_n", {31'h0, bus.ACKD_n}, 32'h1);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ackd_n", {31'h0, bus.ACKD_n}, 32'h1);

        // Word write / read, latency
        access(1'b1, 2'b10, B + 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        check("wr_lat", 32'(lat), 32'd3);
        check("wr_err", {31'h0, er}, 32'h0);
        access(1'b0, 2'b10, B + 32'h10, 32'h0, rd, er, lat);
        check("rd_lat", 32'(lat), 32'd3);
        check("rd_word", rd, 32'hDEAD_BEEF);

        // Byte lanes
        access(1'b1, 2'b10, B + 32'h20, 32'h1122_3344, rd, er, lat);
        access(1'b1, 2'b00, B + 32'h22, 32'hFFFF_FFAA, rd, er, lat);
        access(1'b1, 2'b01, B + 32'h20, 32'hFFFF_5566, rd, er, lat);
        access(1'b0, 2'b10, B + 32'h20, 32'h0, rd, er, lat);
        check("lanes_word", rd, 32'h11AA_5566);
        access(1'b0, 2'b00, B + 32'h23, 32'h0, rd, er, lat);
        check("byte_0x23", rd, 32'h0000_0011);
        access(1'b0, 2'b01, B + 32'h22, 32'h0, rd, er, lat);
        check("half_0x22", rd, 32'h0000_11AA);
        access(1'b0, 2'b00, B + 32'h21, 32'h0, rd, er, lat);
        check("byte_0x21", rd, 32'h0000_0055);

        // Errors
        access(1'b1, 2'b10, B + 32'h21, 32'hFFFF_FFFF, rd, er, lat);
        check("mis_word_err", {31'h0, er}, 32'h1);
        access(1'b0, 2'b10, B + 32'h20, 32'h0, rd, er, lat);
        check("mis_no_write", rd, 32'h11AA_5566);
        access(1'b0, 2'b01, B + 32'h23, 32'h0, rd, er, lat);
        check("mis_half_err", {31'h0, er}, 32'h1);
        check("mis_half_data", rd, 32'h0);
        access(1'b0, 2'b11, B + 32'h20, 32'h0, rd, er, lat);
        check("size11_err", {31'h0, er}, 32'h1);
        check("size11_data", rd, 32'h0);
        access(1'b0, 2'b10, B - 32'h4, 32'h0, rd, er, lat);
        check("below_base_err", {31'h0, er}, 32'h1);
        access(1'b0, 2'b10, B + 32'h1000, 32'h0, rd, er, lat);
        check("above_top_err", {31'h0, er}, 32'h1);
        access(1'b1, 2'b10, B + 32'hFFC, 32'h0BAD_F00D, rd, er, lat);
        check("top_word_err", {31'h0, er}, 32'h0);
        access(1'b0, 2'b10, B + 32'hFFC, 32'h0, rd, er, lat);
        check("top_word_rd", rd, 32'h0BAD_F00D);

        // Abort during WAIT
        access(1'b1, 2'b10, B + 32'h30, 32'h0102_0304, rd, er, lat);
        bus.DAD = B + 32'h30; bus.SIZE = 2'b10; bus.WRITE = 1'b1; bus.MREQ = 1'b1;
        tb_wdata = 32'hFFFF_FFFF; tb_drv_en = 1'b1;
        @(negedge clk);
        bus.MREQ = 1'b0; bus.WRITE = 1'b0; tb_drv_en = 1'b0;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!bus.ACKD_n) lows++;
        end
        check("abort_no_ack", 32'(lows), 32'd0);
        access(1'b0, 2'b10, B + 32'h30, 32'h0, rd, er, lat);
        check("abort_no_write", rd, 32'h0102_0304);
        check("abort_fresh_lat", 32'(lat), 32'd3);

        // Back-to-back, zero wait states
        bus0.DAD = 32'h8; bus0.SIZE = 2'b10; bus0.WRITE = 1'b0; bus0.MREQ = 1'b1;
        #1;
        check("b2b_0", {31'h0, bus0.ACKD_n}, 32'h1);
        @(negedge clk);
        check("b2b_1", {31'h0, bus0.ACKD_n}, 32'h0);
        @(negedge clk);
        check("b2b_2", {31'h0, bus0.ACKD_n}, 32'h1);
        @(negedge clk);
        check("b2b_3", {31'h0, bus0.ACKD_n}, 32'h0);
        check("b2b_err", {31'h0, bus0.err}, 32'h0);
        @(posedge clk);
        #1;
        bus0.MREQ = 1'b0;
        @(negedge clk);

        // Reset asserted during ACK of a store discards it
        access(1'b1, 2'b10, B + 32'h50, 32'h5555_AAAA, rd, er, lat);
        bus.DAD = B + 32'h50; bus.SIZE = 2'b10; bus.WRITE = 1'b1; bus.MREQ = 1'b1;
        tb_wdata = 32'h1234_5678; tb_drv_en = 1'b1;
        lat = 0;
        while (bus.ACKD_n && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rst_pre_ack", {31'h0, bus.ACKD_n}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_async_ackd_n", {31'h0, bus.ACKD_n}, 32'h1);
        bus.MREQ = 1'b0; bus.WRITE = 1'b0; tb_drv_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b0, 2'b10, B + 32'h50, 32'h0, rd, er, lat);
        check("rst_write_discarded", rd, 32'h5555_AAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
